// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: funct3 codes, load-hold FSM states and byte-lane helpers.
// Imported by the MEM/WB load register and the EXE/MEM store aligner.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } ld_hold_e;

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] off);
        return word[8*off +: 8];
    endfunction

    function automatic logic [15:0] lane_half(input logic [31:0] word, input logic upper);
        return upper ? word[31:16] : word[15:0];
    endfunction

    // Write strobes for the store side; halfword lanes follow off[1] only.
    function automatic logic [3:0] store_mask(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_SB:   return 4'b0001 << off;
            F3_SH:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extractor: picks the byte/half lane selected by off and sign/zero extends it.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    output logic [31:0] result
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b      = lane_byte(word, off);
        h      = lane_half(word, off[1]);
        result = word;
        case (funct3)
            F3_LB:   result = {{24{b[7]}}, b};
            F3_LH:   result = {{16{h[15]}}, h};
            F3_LBU:  result = {24'h0, b};
            F3_LHU:  result = {16'h0, h};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/memwb_load_reg.sv
// MEM/WB pipeline register with load alignment and a one-entry buffer for DM data returning during a stall.
// Optional misaligned-load flag on WB_ld_misalign when LOAD_MISALIGN_CHK_EN is defined.
module memwb_load_reg
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   MEM_ALU_out,
    input  logic [XLEN-1:0]   MEM_R_ALUout,
    input  logic [REG_AW-1:0] MEM_write_addr,
    input  logic [2:0]        MEM_funct3,
    input  logic [XLEN-1:0]   MEM_pc,
    input  logic              MEM_RDSrc,
    input  logic              MEM_MemtoReg,
    input  logic              MEM_MemRead,
    input  logic              MEM_RegWrite,
    input  logic              MEM_f_RegWrite,
    input  logic [XLEN-1:0]   DM_DO,
    input  logic              DM_rvalid,
    input  logic              im_stall,
    input  logic              dm_stall,
    input  logic              CSR_stall,
    input  logic              CSR_reset,
    output logic [XLEN-1:0]   WB_ld_data,
    output logic [XLEN-1:0]   WB_ALU_out,
    output logic [XLEN-1:0]   WB_R_ALUout,
    output logic [XLEN-1:0]   WB_pc,
    output logic [REG_AW-1:0] WB_write_addr,
    output logic              WB_RDSrc,
    output logic              WB_MemtoReg,
    output logic              WB_RegWrite,
    output logic              WB_f_RegWrite,
`ifdef LOAD_MISALIGN_CHK_EN
    output logic              WB_ld_misalign,
`endif
    output ld_hold_e          dbg_state,
    output logic [XLEN-1:0]   dbg_hold
);

    ld_hold_e        state_q, state_d;
    logic [XLEN-1:0] hold_q, hold_d;
    logic [XLEN-1:0] src_word, aligned, ld_next;
    logic            stall, have_data, misalign;

    assign stall     = im_stall | dm_stall | CSR_stall;
    assign dbg_state = state_q;
    assign dbg_hold  = hold_q;

    // A pulse arriving during a stall is parked in hold_q; a fresh pulse on the advance cycle wins.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        src_word = DM_DO;
        if (CSR_reset) begin
            state_d = IDLE;
            hold_d  = '0;
        end else if (stall) begin
            if (DM_rvalid) begin
                hold_d  = DM_DO;
                state_d = HOLD;
            end
        end else begin
            state_d  = IDLE;
            src_word = DM_rvalid ? DM_DO : hold_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    load_align u_align (
        .word   (src_word),
        .funct3 (MEM_funct3),
        .off    (MEM_ALU_out[1:0]),
        .result (aligned)
    );

    always_comb begin
        have_data = DM_rvalid || (state_q == HOLD);
        ld_next   = (MEM_MemRead && have_data) ? aligned : '0;
        misalign  = 1'b0;
`ifdef LOAD_MISALIGN_CHK_EN
        misalign  = MEM_MemRead &&
                    ((((MEM_funct3 == F3_LH) || (MEM_funct3 == F3_LHU)) && MEM_ALU_out[0]) ||
                     ((MEM_funct3 == F3_LW) && (MEM_ALU_out[1:0] != 2'b00)));
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset || CSR_reset) begin
            WB_ld_data     <= '0;
            WB_ALU_out     <= '0;
            WB_R_ALUout    <= '0;
            WB_pc          <= '0;
            WB_write_addr  <= '0;
            WB_RDSrc       <= 1'b0;
            WB_MemtoReg    <= 1'b0;
            WB_RegWrite    <= 1'b0;
            WB_f_RegWrite  <= 1'b0;
`ifdef LOAD_MISALIGN_CHK_EN
            WB_ld_misalign <= 1'b0;
`endif
        end else if (!stall) begin
            WB_ld_data     <= ld_next;
            WB_ALU_out     <= MEM_ALU_out;
            WB_R_ALUout    <= MEM_R_ALUout;
            WB_pc          <= MEM_pc;
            WB_write_addr  <= MEM_write_addr;
            WB_RDSrc       <= MEM_RDSrc;
            WB_MemtoReg    <= MEM_MemtoReg;
            // A misaligned load must not retire; the CSR unit traps on the flag instead.
            WB_RegWrite    <= MEM_RegWrite & ~misalign;
            WB_f_RegWrite  <= MEM_f_RegWrite & ~misalign;
`ifdef LOAD_MISALIGN_CHK_EN
            WB_ld_misalign <= misalign;
`endif
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset && !CSR_reset) begin
            assert (!(stall && DM_rvalid && state_q == HOLD))
                else $error("double rvalid");
            assert (!(!stall && MEM_MemRead && state_q == IDLE && !DM_rvalid))
                else $error("load data missing");
        end
    end
`endif

endmodule
